// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//
// Purpose: receiver state enum, oversampling default and the encoding of
// the data-bit-count configuration field.
// Ports: none (package).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int OVERSAMPLE_DEFAULT = 16;

   // cfg_data_bits encoding
   localparam logic [1:0] DATA_BITS_5 = 2'd0;
   localparam logic [1:0] DATA_BITS_6 = 2'd1;
   localparam logic [1:0] DATA_BITS_7 = 2'd2;
   localparam logic [1:0] DATA_BITS_8 = 2'd3;

   // Index of the final data bit for a given cfg_data_bits value (5 bits -> 4).
   function automatic logic [2:0] last_bit_idx(input logic [1:0] cfg);
      return {1'b0, cfg} + 3'd4;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
//
// Purpose: brings an asynchronous level into the clk domain; reusable for
// rx, CTS and RTS. RESET_VAL sets the flop value during reset so an idle-high
// line does not look like an edge when reset is released.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronized output (2-cycle latency)
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 5-8 data bits, optional parity
//
// Purpose: deframes start / data (LSB first) / optional parity / stop from the
// asynchronous rx line, sampling mid-bit on the OVERSAMPLE x baud rx_tick.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx_tick         one-cycle pulse at OVERSAMPLE x baud
//   rx              serial line, idles high
//   cfg_data_bits   0..3 -> 5..8 data bits
//   cfg_parity_en   parity bit present
//   cfg_parity_odd  1 = odd, 0 = even parity
//   rx_data         last received word, right-aligned
//   rx_valid        one-cycle pulse per completed word
//   parity_err      parity mismatch, valid with rx_valid
//   frame_err       stop bit sampled low, valid with rx_valid
//   rx_busy         FSM not in IDLE
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_tick,
   input  logic                  rx,
   input  logic [1:0]            cfg_data_bits,
   input  logic                  cfg_parity_en,
   input  logic                  cfg_parity_odd,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

   rx_state_e             state, state_next;
   logic                  rx_s;
   logic [TW-1:0]         tick_cnt;
   logic [2:0]            bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  parity_bit;
   logic                  armed;
   logic                  at_mid, at_last, last_bit;
   logic                  shift_en, parity_en, stop_en;

   sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_comb begin
      at_mid   = (tick_cnt == TICK_MID);
      at_last  = (tick_cnt == TICK_LAST);
      last_bit = (bit_cnt == last_bit_idx(cfg_data_bits));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; the FSM only moves on rx_tick
   always_comb begin
      state_next = state;
      if (rx_tick) begin
         case (state)
            IDLE:    if (armed && !rx_s) state_next = START;
            START:   if (at_mid)   state_next = rx_s ? IDLE : DATA;
            DATA:    if (at_last && last_bit)
                        state_next = cfg_parity_en ? PARITY : STOP;
            PARITY:  if (at_last)  state_next = STOP;
            STOP:    if (at_last)  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output / strobe decode
   always_comb begin
      rx_busy   = (state != IDLE);
      shift_en  = rx_tick && at_last && (state == DATA);
      parity_en = rx_tick && at_last && (state == PARITY);
      stop_en   = rx_tick && at_last && (state == STOP);
   end

   // Tick and bit counters; tick_cnt restarts on every state change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
      end else if (rx_tick) begin
         if (state_next != state || at_last) begin
            tick_cnt <= '0;
         end else if (state != IDLE) begin
            tick_cnt <= tick_cnt + 1'b1;
         end
         if (state == START) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

   // A start is only accepted after the line has been seen high in IDLE,
   // so a held-low (break) line cannot retrigger a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed <= 1'b0;
      end else if (state != IDLE) begin
         armed <= 1'b0;
      end else if (rx_s) begin
         armed <= 1'b1;
      end
   end

   // Data path: shift register cleared during START so unused upper bits read 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg  <= '0;
         parity_bit <= 1'b0;
      end else if (rx_tick && state == START) begin
         shift_reg  <= '0;
         parity_bit <= 1'b0;
      end else begin
         if (shift_en) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
               if (bit_cnt == i[2:0]) shift_reg[i] <= rx_s;
            end
         end
         if (parity_en) parity_bit <= rx_s;
      end
   end

   // Result registers, loaded on the mid-stop sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (stop_en) begin
            rx_data    <= shift_reg;
            rx_valid   <= 1'b1;
            frame_err  <= ~rx_s;
            parity_err <= cfg_parity_en & (^shift_reg ^ parity_bit ^ cfg_parity_odd);
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

   localparam int TICK_DIV = 4;
   localparam int OS       = 16;
   localparam int BIT_CLKS = TICK_DIV * OS;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_tick = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] cfg_data_bits = 2'd3;
   logic       cfg_parity_en = 1'b0;
   logic       cfg_parity_odd = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       rx_busy;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   tick_div_cnt = 0;
   logic busy_seen = 1'b0;

   uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_tick        (rx_tick),
      .rx             (rx),
      .cfg_data_bits  (cfg_data_bits),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .parity_err     (parity_err),
      .frame_err      (frame_err),
      .rx_busy        (rx_busy)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      rx_tick = (tick_div_cnt == TICK_DIV - 1);
      tick_div_cnt = (tick_div_cnt + 1) % TICK_DIV;
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: pop one expected word per rx_valid cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_busy === 1'b1) busy_seen = 1'b1;
         if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid: got rx_data=%0h, no frame pending", rx_data);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(e.data));
               check("parity_err", 32'(parity_err), 32'(e.perr));
               check("frame_err", 32'(frame_err), 32'(e.ferr));
            end
         end
      end
   end

   task automatic hold_bit(input logic v);
      rx = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   // Drives one frame. abort_bit >= 0 asserts reset in the middle of that data bit.
   task automatic send_frame(input logic [7:0] data, input logic [1:0] dbits,
                             input logic pen, input logic podd, input logic flip,
                             input logic stop_val, input int abort_bit);
      int         nb;
      int         ones;
      logic [7:0] d;
      logic       pbit;
      exp_t       e;
      nb   = int'(dbits) + 5;
      d    = data & 8'((1 << nb) - 1);
      ones = $countones(d);
      // even parity: total ones even; odd parity: total ones odd
      pbit = ((ones % 2) == 1) ^ podd ^ flip;
      cfg_data_bits  = dbits;
      cfg_parity_en  = pen;
      cfg_parity_odd = podd;
      if (abort_bit < 0) begin
         e.data = d;
         e.perr = pen && (((ones + int'(pbit)) % 2) != int'(podd));
         e.ferr = !stop_val;
         exp_q.push_back(e);
      end
      hold_bit(1'b0);
      for (int i = 0; i < nb; i++) begin
         if (i == abort_bit) begin
            rx = d[i];
            repeat (BIT_CLKS / 2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("rst_rx_data", 32'(rx_data), 32'h0);
            check("rst_rx_valid", 32'(rx_valid), 32'h0);
            check("rst_parity_err", 32'(parity_err), 32'h0);
            check("rst_frame_err", 32'(frame_err), 32'h0);
            check("rst_rx_busy", 32'(rx_busy), 32'h0);
            repeat (5) @(negedge clk);
            rx = 1'b1;
            rst_n = 1'b1;
            return;
         end
         hold_bit(d[i]);
      end
      if (pen) hold_bit(pbit);
      hold_bit(stop_val);
   endtask

   initial begin
      logic [7:0] rd;
      logic       stop_v;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_rx_data", 32'(rx_data), 32'h0);
      check("reset_rx_valid", 32'(rx_valid), 32'h0);
      check("reset_parity_err", 32'(parity_err), 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      check("reset_rx_busy", 32'(rx_busy), 32'h0);
      rst_n = 1'b1;
      idle_bits(2);

      // 8N1 baseline
      send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      check("busy_after_8n1", 32'(rx_busy), 32'h0);
      idle_bits(1);

      // 7 bits even parity, correct then flipped parity bit
      send_frame(8'h55, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle_bits(1);
      send_frame(8'h55, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, -1);
      idle_bits(1);

      // Stop bit low
      send_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idle_bits(2);

      // Break: 30 bit-times low gives exactly one frame_err word of zero
      cfg_data_bits = 2'd3;
      cfg_parity_en = 1'b0;
      exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
      rx = 1'b0;
      repeat (30 * BIT_CLKS) @(negedge clk);
      check("break_idle_busy", 32'(rx_busy), 32'h0);
      idle_bits(2);

      // False start: 4-tick glitch
      busy_seen = 1'b0;
      rx = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      rx = 1'b1;
      repeat (10 * TICK_DIV) @(negedge clk);
      check("false_start_busy_seen", 32'(busy_seen), 32'h1);
      check("false_start_idle", 32'(rx_busy), 32'h0);
      idle_bits(1);

      // Back-to-back frames, no idle gap
      send_frame(8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      idle_bits(2);

      // Reset during data bit 3, then resend
      send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      idle_bits(2);
      send_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      idle_bits(1);

      // Randomized frames
      for (int k = 0; k < 24; k++) begin
         rd     = 8'($urandom_range(0, 255));
         stop_v = ($urandom_range(0, 7) != 0);
         send_frame(rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    stop_v, -1);
         if (!stop_v) idle_bits(1);
         else idle_bits($urandom_range(0, 2));
      end

      idle_bits(2);
      check("all_frames_received", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
